ram_port_arbiter: RTL

//  Shares the single-port ram between the instruction-fetch port (I) and the load/store port (D).

---
 rtl/ram_ctrl_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 39 +++
 rtl/ram_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM port arbiter: FSM states, RW encoding, grant ids.
package ram_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StAck
    } state_e;

    localparam logic RwRead  = 1'b1;
    localparam logic RwWrite = 1'b0;

    localparam int unsigned GntI = 0;
    localparam int unsigned GntD = 1;

    // Wide enough for the largest legal read latency (7).
    localparam int unsigned CntW = 3;

    function automatic logic [CntW-1:0] rd_cnt_init(input int unsigned rd_lat);
        return CntW'(rd_lat - 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a conflict the port that did not win last time is granted.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    input  logic       en_i,
    output logic [1:0] gnt_o,
    output logic       last_o
);

    always_comb begin
        gnt_o  = 2'b00;
        last_o = last_i;
        if (en_i) begin
            unique case (req_i)
                2'b01: begin
                    gnt_o[GntI] = 1'b1;
                    last_o      = 1'(GntI);
                end
                2'b10: begin
                    gnt_o[GntD] = 1'b1;
                    last_o      = 1'(GntD);
                end
                2'b11: begin
                    if (last_i == 1'(GntD)) begin
                        gnt_o[GntI] = 1'b1;
                        last_o      = 1'(GntI);
                    end else begin
                        gnt_o[GntD] = 1'b1;
                        last_o      = 1'(GntD);
                    end
                end
                default: gnt_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between the fetch (I) and load/store (D) ports, sequencing
// each access as grant, enable, optional read wait, capture and a one-cycle acknowledge.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          i_req_i,
    input  logic [AW-1:0] i_addr_i,
    output logic [DW-1:0] i_rdata_o,
    output logic          i_ack_o,

    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_ack_o,

    output logic [AW-1:0] ram_addr_o,
    output logic          ram_rw_o,
    output logic [DW-1:0] ram_din_o,
    output logic          ram_f_o,
    output logic          ram_en_o,
    input  logic [DW-1:0] ram_dout_i,
    input  logic [DW-1:0] ram_fetch_i,

    output logic          busy_o
);

    localparam logic [CntW-1:0] CntInit = rd_cnt_init(RD_LAT);

    state_e          state_q, state_d;
    logic            last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rw_q, rw_d;
    logic [DW-1:0]   din_q, din_d;
    logic            f_q, f_d;
    logic            sel_q, sel_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

    logic [1:0]      gnt;

    rr_arb2 u_arb (
        .req_i  ({d_req_i, i_req_i}),
        .last_i (last_q),
        .en_i   (state_q == StIdle),
        .gnt_o  (gnt),
        .last_o (last_d)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        din_d     = din_q;
        f_d       = f_q;
        sel_d     = sel_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    state_d = StIssue;
                    sel_d   = gnt[GntD];
                    if (gnt[GntD]) begin
                        addr_d = d_addr_i;
                        rw_d   = ~d_we_i;
                        din_d  = d_wdata_i;
                        f_d    = 1'b0;
                    end else begin
                        addr_d = i_addr_i;
                        rw_d   = RwRead;
                        f_d    = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (rw_q == RwWrite) begin
                    state_d = StAck;
                end else begin
                    cnt_d   = CntInit;
                    state_d = (CntInit == '0) ? StAck : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Read data is sampled on the edge that enters StAck.
        if (state_q != StAck && state_d == StAck && rw_q == RwRead) begin
            if (sel_q) begin
                d_rdata_d = ram_dout_i;
            end else begin
                i_rdata_d = ram_fetch_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            last_q    <= 1'(GntI);
            cnt_q     <= '0;
            addr_q    <= '0;
            rw_q      <= RwRead;
            din_q     <= '0;
            f_q       <= 1'b0;
            sel_q     <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            din_q     <= din_d;
            f_q       <= f_d;
            sel_q     <= sel_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign ram_addr_o = addr_q;
    assign ram_rw_o   = rw_q;
    assign ram_din_o  = din_q;
    assign ram_f_o    = f_q;
    assign ram_en_o   = (state_q == StIssue);
    assign i_ack_o    = (state_q == StAck) && !sel_q;
    assign d_ack_o    = (state_q == StAck) && sel_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign busy_o     = (state_q != StIdle);

endmodule
